// File: rtl/fsm_stream_scheduler.sv
// Round-robin sharing of one serial sequence-detector FSM between two word requesters.
// Each granted word is shifted MSB-first into the detector, and the cycles with y_in != 0 are counted.
module fsm_stream_scheduler #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             x,
  output logic             fsm_rst,
  input  logic [1:0]       y_in,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] hits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  logic               ptr_r;
  logic [WIDTH-1:0]   sreg_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   hits_r;
  logic               done_id_r;
  logic               x_r;
  logic               fsm_rst_r;
  logic               gnt0_r;
  logic               gnt1_r;
  logic               busy_r;
  logic               done_r;

  logic               grant_any_s;
  logic               pick_s;
  logic [WIDTH-1:0]   pick_data_s;

  // Arbitration: ptr only breaks ties when both requesters are pending
  always_comb begin
    grant_any_s = req0 | req1;
    if (req0 && req1) begin
      pick_s = ptr_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      pick_data_s = data1;
    end else begin
      pick_data_s = data0;
    end
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= 1'b0;
      sreg_r    <= '0;
      cnt_r     <= '0;
      hits_r    <= '0;
      done_id_r <= 1'b0;
      x_r       <= 1'b0;
      fsm_rst_r <= 1'b1;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            // MSB goes out in the grant cycle itself; the rest waits in sreg
            x_r       <= pick_data_s[WIDTH-1];
            sreg_r    <= {pick_data_s[WIDTH-2:0], 1'b0};
            fsm_rst_r <= 1'b0;
            hits_r    <= '0;
            cnt_r     <= '0;
            ptr_r     <= ~pick_s;
            done_id_r <= pick_s;
            gnt0_r    <= ~pick_s;
            gnt1_r    <= pick_s;
            busy_r    <= 1'b1;
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
          // The detector output lags x by one cycle, so cycle 0 has nothing to sample yet
          if ((cnt_r != '0) && (y_in != 2'b00)) begin
            hits_r <= hits_r + CNT_W'(1);
          end
          if (cnt_r == LAST_BIT) begin
            x_r     <= 1'b0;
            state_r <= FLUSH;
          end else begin
            x_r    <= sreg_r[WIDTH-1];
            sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        FLUSH: begin
          if (y_in != 2'b00) begin
            hits_r <= hits_r + CNT_W'(1);
          end
          fsm_rst_r <= 1'b1;
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          x_r       <= 1'b0;
          fsm_rst_r <= 1'b1;
          gnt0_r    <= 1'b0;
          gnt1_r    <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_r;
  assign gnt1    = gnt1_r;
  assign x       = x_r;
  assign fsm_rst = fsm_rst_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign hits    = hits_r;

endmodule
